// File: rtl/offset_pkg.sv
// Shared types and helpers for the address-offset encoder and its matching decoder.
package offset_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHORT,
        ESC,
        CHUNK
    } offset_state_e;

    // Reserved escape code: the most negative value of a width-bit signed beat.
    function automatic int offset_esc(input int width);
        return 1 << (width - 1);
    endfunction

    function automatic int offset_num_chunks(input int addr_w, input int off_w);
        return (addr_w + off_w - 1) / off_w;
    endfunction

endpackage

// File: rtl/offset_fit.sv
// Decides whether an address delta fits in one signed short beat (escape code excluded).
module offset_fit
    import offset_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int OFFSET_WIDTH = 12
) (
    input  logic [ADDR_WIDTH-1:0]   delta,
    output logic                    fit,
    output logic [OFFSET_WIDTH-1:0] beat
);

    localparam logic [OFFSET_WIDTH-1:0] ESC_BEAT = OFFSET_WIDTH'(offset_esc(OFFSET_WIDTH));

    // Sign bit of the short beat plus every bit above it must agree.
    logic [ADDR_WIDTH-OFFSET_WIDTH:0] top;

    assign top  = delta[ADDR_WIDTH-1:OFFSET_WIDTH-1];
    assign beat = delta[OFFSET_WIDTH-1:0];
    assign fit  = ((&top) || !(|top)) && (beat != ESC_BEAT);

endmodule

// File: rtl/offset_encoder.sv
// Streaming address-delta encoder: one short signed offset beat per address, or an
// escape beat followed by the full address in LSB-first chunks.
module offset_encoder
    import offset_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int OFFSET_WIDTH = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   in_addr,
    input  logic                    in_clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [OFFSET_WIDTH-1:0] out_data,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int NUM_CHUNKS = offset_num_chunks(ADDR_WIDTH, OFFSET_WIDTH);
    localparam int PAD_WIDTH  = NUM_CHUNKS * OFFSET_WIDTH;
    localparam int CW         = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NUM_CHUNKS - 1);
    localparam logic [OFFSET_WIDTH-1:0] ESC_BEAT = OFFSET_WIDTH'(offset_esc(OFFSET_WIDTH));

    offset_state_e           state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   ref_q, ref_d;
    logic [PAD_WIDTH-1:0]    addr_q, addr_d;
    logic [OFFSET_WIDTH-1:0] data_q, data_d;
    logic                    last_q, last_d;

    logic [ADDR_WIDTH-1:0]   base;
    logic [ADDR_WIDTH-1:0]   delta;
    logic                    fit;
    logic [OFFSET_WIDTH-1:0] short_beat;
    logic                    accept;
    logic                    handshake;

    assign base  = in_clear ? '0 : ref_q;
    assign delta = in_addr - base;

    offset_fit #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .OFFSET_WIDTH(OFFSET_WIDTH)
    ) u_fit (
        .delta(delta),
        .fit  (fit),
        .beat (short_beat)
    );

    assign out_valid = (state_q != IDLE);
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign handshake = out_valid && out_ready;
    // Finishing the last beat of a token frees the slot in the same cycle.
    assign in_ready  = (state_q == IDLE) || (handshake && last_q);
    assign accept    = in_valid && in_ready;

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        ref_d   = ref_q;
        addr_d  = addr_q;
        data_d  = data_q;
        last_d  = last_q;

        if (handshake) begin
            case (state_q)
                SHORT: begin
                    state_d = IDLE;
                    data_d  = '0;
                    last_d  = 1'b0;
                end
                ESC: begin
                    state_d = CHUNK;
                    cnt_d   = '0;
                    data_d  = addr_q[OFFSET_WIDTH-1:0];
                    last_d  = (NUM_CHUNKS == 1);
                end
                CHUNK: begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        data_d  = '0;
                        last_d  = 1'b0;
                    end else begin
                        cnt_d  = cnt_q + CW'(1);
                        addr_d = addr_q >> OFFSET_WIDTH;
                        data_d = addr_d[OFFSET_WIDTH-1:0];
                        last_d = (cnt_d == LAST_CNT);
                    end
                end
                default: ;
            endcase
        end

        // An accept only happens when the slot is free, so it overrides the drain above.
        if (accept) begin
            ref_d = in_addr;
            cnt_d = '0;
            if (fit) begin
                state_d = SHORT;
                data_d  = short_beat;
                last_d  = 1'b1;
            end else begin
                state_d = ESC;
                data_d  = ESC_BEAT;
                last_d  = 1'b0;
                addr_d  = PAD_WIDTH'(in_addr);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ref_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ref_q   <= ref_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_offset_encoder.sv
// Self-checking bench for offset_encoder: directed scenarios plus randomized traffic
// against a queue-based reference model of the token format.
module tb_offset_encoder;

    typedef struct {
        logic [11:0] data;
        logic        last;
        int          cyc;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_addr;
    logic        in_clear;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] out_data;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;

    logic [12:0] q[$];
    beat_t       log_q[$];
    logic [31:0] ref_m;
    bit          prev_hold;
    logic [11:0] prev_data;
    logic        prev_last;
    bit          accepted;

    always #5 clk = ~clk;

    offset_encoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_addr  (in_addr),
        .in_clear (in_clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_last (out_last),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Reference model: signed distance test, then either one beat or escape + 3 chunks.
    function automatic void model_accept(input logic [31:0] a, input logic clr);
        logic [31:0] d;
        int          sd;
        d  = a - (clr ? 32'h0 : ref_m);
        sd = int'(d);
        if (sd >= -2047 && sd <= 2047) begin
            q.push_back({1'b1, d[11:0]});
        end else begin
            q.push_back({1'b0, 12'h800});
            q.push_back({1'b0, a[11:0]});
            q.push_back({1'b0, a[23:12]});
            q.push_back({1'b1, 4'h0, a[31:24]});
        end
        ref_m = a;
    endfunction

    task automatic step(input logic v, input logic [31:0] a, input logic clr, input logic ordy);
        logic        exp_valid;
        logic        exp_ready;
        logic [12:0] front;
        in_valid  = v;
        in_addr   = a;
        in_clear  = clr;
        out_ready = ordy;
        #1;
        exp_valid = (q.size() != 0);
        exp_ready = (q.size() == 0) || (q.size() == 1 && ordy);
        checks++;
        if (out_valid !== exp_valid) begin
            errors++;
            $display("FAIL out_valid cyc %0d: got %b expected %b", cyc, out_valid, exp_valid);
        end
        checks++;
        if (in_ready !== exp_ready) begin
            errors++;
            $display("FAIL in_ready cyc %0d: got %b expected %b", cyc, in_ready, exp_ready);
        end
        if (prev_hold) begin
            checks++;
            if ({out_last, out_data} !== {prev_last, prev_data}) begin
                errors++;
                $display("FAIL hold_stable cyc %0d: got %b/%h expected %b/%h",
                         cyc, out_last, out_data, prev_last, prev_data);
            end
        end
        if (exp_valid && ordy) begin
            front = q.pop_front();
            checks++;
            if ({out_last, out_data} !== front) begin
                errors++;
                $display("FAIL beat cyc %0d: got last=%b data=%h expected last=%b data=%h",
                         cyc, out_last, out_data, front[12], front[11:0]);
            end
            log_q.push_back('{out_data, out_last, cyc});
        end
        prev_hold = exp_valid && !ordy;
        prev_data = out_data;
        prev_last = out_last;
        accepted  = v && exp_ready;
        if (accepted) model_accept(a, clr);
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            step(1'b0, 32'h0, 1'b0, 1'b1);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d beats left, expected 0", q.size());
        end
    endtask

    task automatic send(input logic [31:0] a, input logic clr);
        int n = 0;
        accepted = 1'b0;
        while (!accepted && n < 20) begin
            step(1'b1, a, clr, 1'b1);
            n++;
        end
        checks++;
        if (!accepted) begin
            errors++;
            $display("FAIL accept_timeout addr %h: got no accept, expected one", a);
        end
        drain();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_clear = 1'b0; out_ready = 1'b0;
        q.delete(); ref_m = '0; prev_hold = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_last, out_data, in_ready} !== {1'b0, 1'b0, 12'h000, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: got valid=%b last=%b data=%h ready=%b expected 0 0 000 1",
                     out_valid, out_last, out_data, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_short();
        log_q.delete();
        send(32'h123, 1'b0);
        send(32'h122, 1'b0);
        checks++;
        if (log_q.size() != 2) begin
            errors++;
            $display("FAIL short_len: got %0d expected 2", log_q.size());
        end else begin
            checks++;
            if ({log_q[0].last, log_q[0].data} !== 13'h1123) begin
                errors++;
                $display("FAIL short_123: got %b/%h expected 1/123", log_q[0].last, log_q[0].data);
            end
            checks++;
            if ({log_q[1].last, log_q[1].data} !== 13'h1FFF) begin
                errors++;
                $display("FAIL short_neg1: got %b/%h expected 1/fff", log_q[1].last, log_q[1].data);
            end
        end
        send(32'hFFFF_FFFF, 1'b0);
        log_q.delete();
        send(32'h0000_0001, 1'b0);
        checks++;
        if (log_q.size() != 1 || {log_q[0].last, log_q[0].data} !== 13'h1002) begin
            errors++;
            $display("FAIL short_wrap: got %0d beats, first %h expected 1 beat 1/002",
                     log_q.size(), log_q.size() ? {log_q[0].last, log_q[0].data} : 13'h0);
        end
    endtask

    task automatic test_long();
        logic [12:0] exp_a[4];
        logic [12:0] exp_b[4];
        exp_a = '{13'h0800, 13'h0800, 13'h0001, 13'h1000};
        exp_b = '{13'h0800, 13'h0800, 13'h0000, 13'h1000};
        send(32'h1000, 1'b0);
        log_q.delete();
        send(32'h1800, 1'b0);
        checks++;
        if (log_q.size() != 4) begin
            errors++;
            $display("FAIL long_plus_len: got %0d expected 4", log_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if ({log_q[i].last, log_q[i].data} !== exp_a[i]) begin
                    errors++;
                    $display("FAIL long_plus beat %0d: got %h expected %h",
                             i, {log_q[i].last, log_q[i].data}, exp_a[i]);
                end
            end
        end
        send(32'h1000, 1'b0);
        log_q.delete();
        send(32'h800, 1'b0);
        checks++;
        if (log_q.size() != 4) begin
            errors++;
            $display("FAIL long_esc_len: got %0d expected 4", log_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if ({log_q[i].last, log_q[i].data} !== exp_b[i]) begin
                    errors++;
                    $display("FAIL long_esc beat %0d: got %h expected %h",
                             i, {log_q[i].last, log_q[i].data}, exp_b[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] exp_c[4];
        logic [31:0] adds[4];
        exp_c = '{13'h0800, 13'h0123, 13'h0CDE, 13'h10AB};
        log_q.delete();
        step(1'b1, 32'hABCD_E123, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 32'h55, 1'b0, 1'b0);
        drain();
        checks++;
        if (log_q.size() != 4) begin
            errors++;
            $display("FAIL backpressure_len: got %0d expected 4", log_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if ({log_q[i].last, log_q[i].data} !== exp_c[i]) begin
                    errors++;
                    $display("FAIL backpressure beat %0d: got %h expected %h",
                             i, {log_q[i].last, log_q[i].data}, exp_c[i]);
                end
            end
        end
        adds = '{32'hABCD_E124, 32'hABCD_E126, 32'hABCD_E123, 32'hABCD_E187};
        log_q.delete();
        for (int i = 0; i < 4; i++) step(1'b1, adds[i], 1'b0, 1'b1);
        drain();
        checks++;
        if (log_q.size() != 4) begin
            errors++;
            $display("FAIL b2b_len: got %0d expected 4", log_q.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (log_q[i].cyc != log_q[0].cyc + i) begin
                    errors++;
                    $display("FAIL b2b_gap beat %0d: got cycle %0d expected %0d",
                             i, log_q[i].cyc, log_q[0].cyc + i);
                end
            end
        end
    endtask

    task automatic test_clear();
        send(32'h9000, 1'b0);
        log_q.delete();
        send(32'h5, 1'b1);
        checks++;
        if (log_q.size() != 1 || {log_q[0].last, log_q[0].data} !== 13'h1005) begin
            errors++;
            $display("FAIL clear: got %0d beats, first %h expected 1 beat 1/005",
                     log_q.size(), log_q.size() ? {log_q[0].last, log_q[0].data} : 13'h0);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 32'h1234_5678, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_last, out_data, in_ready} !== {1'b0, 1'b0, 12'h000, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid: got valid=%b last=%b data=%h ready=%b expected 0 0 000 1",
                     out_valid, out_last, out_data, in_ready);
        end
        q.delete();
        ref_m     = '0;
        prev_hold = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        log_q.delete();
        send(32'h10, 1'b0);
        checks++;
        if (log_q.size() != 1 || {log_q[0].last, log_q[0].data} !== 13'h1010) begin
            errors++;
            $display("FAIL after_reset: got %0d beats, first %h expected 1 beat 1/010",
                     log_q.size(), log_q.size() ? {log_q[0].last, log_q[0].data} : 13'h0);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic        v, clr, ordy;
        int          off;
        for (int i = 0; i < 500; i++) begin
            v    = ($urandom % 3) != 0;
            clr  = ($urandom % 8) == 0;
            ordy = ($urandom % 4) != 0;
            off  = int'($urandom_range(0, 4200)) - 2100;
            if (($urandom % 6) == 0) a = $urandom;
            else if (clr)            a = 32'(off);
            else                     a = ref_m + 32'(off);
            step(v, a, clr, ordy);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_short();
        test_long();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
